// File: rtl/limb_pkg.sv
// Shared types and bus encodings for the processor memory arbiter.
// Used by memory_arbiter and memory_arbiter_select.
package limb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [1:0] TRANS_IDLE  = 2'b00;
  localparam logic [1:0] TRANS_NSEQ  = 2'b10;
  localparam logic [1:0] TRANS_SEQ   = 2'b11;

  localparam logic [1:0] PROT_OPCODE = 2'b00;
  localparam logic [1:0] PROT_DATA   = 2'b01;

  function automatic logic [1:0] prot_of(owner_e o);
    return (o == OWN_DATA) ? PROT_DATA : PROT_OPCODE;
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational grant picker for the fetch and data channels.
// MEMORY_ARBITER_ROUND_ROBIN_EN selects alternating priority on contention.
module memory_arbiter_select
  import limb_pkg::*;
(
  input  logic   f_req_i,
  input  logic   d_req_i,
  input  logic   en_i,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  input  owner_e pref_i,
`endif
  output logic   f_gnt_o,
  output logic   d_gnt_o
);

  logic pick_d;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // pref_i names the channel that wins the next tie
  always_comb begin
    pick_d = d_req_i;
    if (f_req_i && d_req_i) begin
      pick_d = (pref_i == OWN_DATA);
    end
  end
`else
  always_comb begin
    pick_d = d_req_i;
  end
`endif

  always_comb begin
    d_gnt_o = en_i & pick_d;
    f_gnt_o = en_i & f_req_i & ~pick_d;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-port memory bus between fetch and data channels.
// Optional MEMORY_ARBITER_ROUND_ROBIN_EN alternates priority on contention.
module memory_arbiter
  import limb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_write,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_size,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_abort,
  output logic          mem_write,
  output logic          mem_size,
  output logic [1:0]    mem_prot,
  output logic [1:0]    mem_trans
);

  arb_state_e    state_q, state_d;

  owner_e        own_q, own_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          size_q, size_d;
  logic [1:0]    prot_q, prot_d;
  logic [1:0]    trans_q, trans_d;
  logic          prev_v_q;

  logic          gnt_en;
  logic          any_gnt;
  logic          is_seq;
  logic [AW:0]   addr_inc;
  logic          rsp_v;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  owner_e        pref_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pref_q <= OWN_FETCH;
    end else if (any_gnt) begin
      pref_q <= d_gnt ? OWN_FETCH : OWN_DATA;
    end
  end
`endif

  always_comb begin
    gnt_en = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && !reset;
  end

  memory_arbiter_select u_select (
    .f_req_i (f_req),
    .d_req_i (d_req),
    .en_i    (gnt_en),
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    .pref_i  (pref_q),
`endif
    .f_gnt_o (f_gnt),
    .d_gnt_o (d_gnt)
  );

  // Carry out of the increment must not match, so compare in AW+1 bits
  always_comb begin
    any_gnt  = f_gnt | d_gnt;
    own_d    = d_gnt ? OWN_DATA : OWN_FETCH;
    addr_d   = d_gnt ? d_addr : f_addr;
    wdata_d  = d_gnt ? d_wdata : '0;
    write_d  = d_gnt & d_write;
    size_d   = d_gnt ? d_size : 1'b1;
    prot_d   = prot_of(own_d);
    addr_inc = {1'b0, addr_q} + {{AW{1'b0}}, 1'b1};
    is_seq   = prev_v_q && (own_d == own_q)
               && ({1'b0, addr_d} == addr_inc);
    trans_d  = is_seq ? TRANS_SEQ : TRANS_NSEQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_gnt) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        state_d = any_gnt ? ST_ADDR : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q    <= OWN_FETCH;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= 1'b0;
      prot_q   <= 2'b00;
      trans_q  <= TRANS_IDLE;
      prev_v_q <= 1'b0;
    end else if (any_gnt) begin
      own_q    <= own_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      size_q   <= size_d;
      prot_q   <= prot_d;
      trans_q  <= trans_d;
      prev_v_q <= 1'b1;
    end
  end

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_size  = size_q;
    mem_prot  = prot_q;
    mem_write = (state_q == ST_ADDR) & write_q;
    mem_trans = (state_q == ST_ADDR) ? trans_q : TRANS_IDLE;
  end

  always_comb begin
    rsp_v    = (state_q == ST_DATA);
    f_rvalid = rsp_v && (own_q == OWN_FETCH);
    d_rvalid = rsp_v && (own_q == OWN_DATA);
    f_rdata  = f_rvalid ? mem_rdata : '0;
    d_rdata  = (d_rvalid && !write_q) ? mem_rdata : '0;
    f_err    = f_rvalid & mem_abort;
    d_err    = d_rvalid & mem_abort;
  end

endmodule
